// File: rtl/bank_timing_fsm_array.sv
// Per-bank DRAM timing state machine array: tracks row state for every (bank group, bank)
// and enforces tRCD/tCL/tCWL/tWR/tRP/tRFC with per-bank down-counters and error reporting.
module bank_timing_fsm_array #(
  parameter int BGWIDTH = 2,
  parameter int BAWIDTH = 2,
  parameter int BL      = 8,
  parameter int T_RCD   = 17,
  parameter int T_CL    = 17,
  parameter int T_CWL   = 12,
  parameter int T_WR    = 14,
  parameter int T_RP    = 17,
  parameter int T_RFC   = 34
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic [((BGWIDTH > 0) ? BGWIDTH : 1)-1:0]   bg,
  input  logic [BAWIDTH-1:0]                         ba,
  input  logic                                       ACT,
  input  logic                                       RD,
  input  logic                                       RDA,
  input  logic                                       WR,
  input  logic                                       WRA,
  input  logic                                       PR,
  input  logic                                       PRA,
  input  logic                                       REF,
  output logic [5*(1 << (BGWIDTH+BAWIDTH))-1:0]      bank_state,
  output logic [(1 << (BGWIDTH+BAWIDTH))-1:0]        bank_ready,
  output logic                                       cmd_err,
  output logic [BGWIDTH+BAWIDTH-1:0]                 err_bank
);

  localparam int IW   = BGWIDTH + BAWIDTH;
  localparam int NB   = 1 << IW;
  localparam int D_RD = T_CL + BL / 2;
  localparam int D_WR = T_CWL + BL / 2 + T_WR;

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int D_MAX = imax(imax(imax(D_WR, T_RCD), imax(D_RD, T_RP)), T_RFC);
  localparam int CW    = $clog2(D_MAX + 1);

  // Counters are loaded with duration-1 so the state exits on the edge where cnt reaches 0.
  localparam logic [CW-1:0] L_RCD = CW'(T_RCD - 1);
  localparam logic [CW-1:0] L_RD  = CW'(D_RD - 1);
  localparam logic [CW-1:0] L_WR  = CW'(D_WR - 1);
  localparam logic [CW-1:0] L_RP  = CW'(T_RP - 1);
  localparam logic [CW-1:0] L_RFC = CW'(T_RFC - 1);

  typedef enum logic [4:0] {
    S_IDLE         = 5'h00,
    S_ACTIVATING   = 5'h01,
    S_ACTIVE       = 5'h03,
    S_READING      = 5'h04,
    S_WRITING      = 5'h05,
    S_READ_AP      = 5'h06,
    S_WRITE_AP     = 5'h07,
    S_PRECHARGING  = 5'h08,
    S_REFRESHING   = 5'h09
  } bank_st_e;

  bank_st_e      state_q [NB];
  bank_st_e      state_d [NB];
  logic [CW-1:0] cnt_q   [NB];
  logic [CW-1:0] cnt_d   [NB];
  logic          cmd_err_q;
  logic [IW-1:0] err_bank_q;

  logic [IW-1:0] idx;
  logic [7:0]    strobes;
  logic [NB-1:0] hit;
  logic          all_idle;
  logic          all_rest;
  logic          cmd_ok;
  logic          cmd_bad;
  bank_st_e      tgt_st;

  if (BGWIDTH > 0) begin : g_bg
    assign idx = {bg, ba};
  end else begin : g_no_bg
    assign idx = ba;
  end

  assign strobes = {ACT, RD, RDA, WR, WRA, PR, PRA, REF};

  always_comb begin
    for (int b = 0; b < NB; b++) begin
      bank_state[5*b +: 5] = state_q[b];
      bank_ready[b]        = (state_q[b] == S_IDLE) || (state_q[b] == S_ACTIVE);
    end
  end

  // Legality is judged against the registered (pre-edge) state of the addressed bank.
  always_comb begin
    // NOTE: every variable written here gets a default before any branch, so no latch is inferred.
    all_idle = 1'b1;
    cmd_ok   = 1'b0;
    tgt_st   = state_q[idx];
    all_rest = &bank_ready;
    for (int b = 0; b < NB; b++) begin
      all_idle = all_idle && (state_q[b] == S_IDLE);
    end
    if ($countones(strobes) == 1) begin
      if (ACT)                          cmd_ok = (tgt_st == S_IDLE);
      else if (RD || RDA || WR || WRA)  cmd_ok = (tgt_st == S_ACTIVE);
      else if (PR)                      cmd_ok = (tgt_st == S_IDLE) || (tgt_st == S_ACTIVE);
      else if (PRA)                     cmd_ok = all_rest;
      else                              cmd_ok = all_idle;
    end
    cmd_bad = (strobes != 8'h00) && !cmd_ok;
    for (int b = 0; b < NB; b++) begin
      hit[b] = cmd_ok && (idx == IW'(b));
    end
  end

  always_comb begin
    for (int b = 0; b < NB; b++) begin
      state_d[b] = state_q[b];
      cnt_d[b]   = cnt_q[b];
      case (state_q[b])
        S_IDLE: begin
          if (hit[b] && ACT) begin
            state_d[b] = S_ACTIVATING;
            cnt_d[b]   = L_RCD;
          end else if (cmd_ok && REF) begin
            state_d[b] = S_REFRESHING;
            cnt_d[b]   = L_RFC;
          end
        end
        S_ACTIVE: begin
          if (hit[b] && RD) begin
            state_d[b] = S_READING;
            cnt_d[b]   = L_RD;
          end else if (hit[b] && RDA) begin
            state_d[b] = S_READ_AP;
            cnt_d[b]   = L_RD;
          end else if (hit[b] && WR) begin
            state_d[b] = S_WRITING;
            cnt_d[b]   = L_WR;
          end else if (hit[b] && WRA) begin
            state_d[b] = S_WRITE_AP;
            cnt_d[b]   = L_WR;
          end else if ((hit[b] && PR) || (cmd_ok && PRA)) begin
            state_d[b] = S_PRECHARGING;
            cnt_d[b]   = L_RP;
          end
        end
        default: begin
          if (cnt_q[b] != '0) begin
            cnt_d[b] = cnt_q[b] - CW'(1);
          end else begin
            case (state_q[b])
              S_ACTIVATING, S_READING, S_WRITING: state_d[b] = S_ACTIVE;
              S_READ_AP, S_WRITE_AP: begin
                state_d[b] = S_PRECHARGING;
                cnt_d[b]   = L_RP;
              end
              default: state_d[b] = S_IDLE;
            endcase
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the per-bank state and counter arrays are reset element by element so that a reset aborts every timed state.
      for (int b = 0; b < NB; b++) begin
        state_q[b] <= S_IDLE;
        cnt_q[b]   <= '0;
      end
      cmd_err_q  <= 1'b0;
      err_bank_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every bank samples the same pre-edge state.
      for (int b = 0; b < NB; b++) begin
        state_q[b] <= state_d[b];
        cnt_q[b]   <= cnt_d[b];
      end
      cmd_err_q <= cmd_bad;
      if (cmd_bad) err_bank_q <= idx;
    end
  end

  assign cmd_err  = cmd_err_q;
  assign err_bank = err_bank_q;

endmodule

// File: tb/tb_bank_timing_fsm_array.sv
// Bench for bank_timing_fsm_array: directed scenarios plus random commands, checked by a
// scoreboard fed from a per-bank timeline model (state phases with absolute end times).
module tb_bank_timing_fsm_array;

  localparam int NB    = 16;
  localparam int BL    = 8;
  localparam int T_RCD = 17;
  localparam int T_CL  = 17;
  localparam int T_CWL = 12;
  localparam int T_WR  = 14;
  localparam int T_RP  = 17;
  localparam int T_RFC = 34;
  localparam int D_RD  = T_CL + BL / 2;
  localparam int D_WR  = T_CWL + BL / 2 + T_WR;

  localparam logic [4:0] IDLE = 5'h00, ACTG = 5'h01, ACTV = 5'h03, RDG = 5'h04, WRG = 5'h05;
  localparam logic [4:0] RDAP = 5'h06, WRAP = 5'h07, PREC = 5'h08, REFR = 5'h09;
  localparam int B_ACT = 7, B_RD = 6, B_RDA = 5, B_WR = 4, B_WRA = 3, B_PR = 2, B_PRA = 1, B_REF = 0;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  bg = '0;
  logic [1:0]  ba = '0;
  logic        ACT = 0, RD = 0, RDA = 0, WR = 0, WRA = 0, PR = 0, PRA = 0, REF = 0;
  logic [79:0] bank_state;
  logic [15:0] bank_ready;
  logic        cmd_err;
  logic [3:0]  err_bank;

  bank_timing_fsm_array #(
    .BGWIDTH(2), .BAWIDTH(2), .BL(BL), .T_RCD(T_RCD), .T_CL(T_CL), .T_CWL(T_CWL),
    .T_WR(T_WR), .T_RP(T_RP), .T_RFC(T_RFC)
  ) dut (
    .clk(clk), .reset(reset), .bg(bg), .ba(ba),
    .ACT(ACT), .RD(RD), .RDA(RDA), .WR(WR), .WRA(WRA), .PR(PR), .PRA(PRA), .REF(REF),
    .bank_state(bank_state), .bank_ready(bank_ready), .cmd_err(cmd_err), .err_bank(err_bank)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, got, exp);
    end
  endtask

  typedef struct {
    int          cyc;
    logic [79:0] st;
    logic [15:0] rdy;
    logic        err;
    logic [3:0]  eb;
  } exp_t;
  exp_t sb[$];

  // Reference model: each bank rests in IDLE or ACTIVE and holds up to two timed phases,
  // each shown until an absolute edge number.
  logic [4:0] rest   [NB];
  logic [4:0] ph_st  [NB][2];
  int         ph_end [NB][2];
  int         ph_n   [NB];
  int         mt;
  logic [3:0] exp_eb;

  function automatic logic [4:0] view(input int b, input int t);
    for (int i = 0; i < ph_n[b]; i++) if (ph_end[b][i] > t) return ph_st[b][i];
    return rest[b];
  endfunction

  task automatic sched(input int b, input int t, input logic [4:0] s1, input int d1,
                       input logic [4:0] s2, input int d2, input logic [4:0] r);
    ph_st[b][0]  = s1;
    ph_end[b][0] = t + d1;
    ph_st[b][1]  = s2;
    ph_end[b][1] = t + d1 + d2;
    ph_n[b]      = (d2 > 0) ? 2 : 1;
    rest[b]      = r;
  endtask

  task automatic model_reset();
    mt     = 0;
    exp_eb = '0;
    for (int i = 0; i < NB; i++) begin
      rest[i] = IDLE;
      ph_n[i] = 0;
    end
  endtask

  task automatic model_edge(input logic [7:0] s, input int b, output logic err);
    logic [4:0] pre [NB];
    logic ok;
    int t;
    mt++;
    t  = mt;
    ok = 1'b1;
    for (int i = 0; i < NB; i++) pre[i] = view(i, t - 1);
    if ($countones(s) > 1) ok = 1'b0;
    else if (s[B_ACT]) begin
      if (pre[b] == IDLE) sched(b, t, ACTG, T_RCD, IDLE, 0, ACTV); else ok = 1'b0;
    end else if (s[B_RD]) begin
      if (pre[b] == ACTV) sched(b, t, RDG, D_RD, IDLE, 0, ACTV); else ok = 1'b0;
    end else if (s[B_WR]) begin
      if (pre[b] == ACTV) sched(b, t, WRG, D_WR, IDLE, 0, ACTV); else ok = 1'b0;
    end else if (s[B_RDA]) begin
      if (pre[b] == ACTV) sched(b, t, RDAP, D_RD, PREC, T_RP, IDLE); else ok = 1'b0;
    end else if (s[B_WRA]) begin
      if (pre[b] == ACTV) sched(b, t, WRAP, D_WR, PREC, T_RP, IDLE); else ok = 1'b0;
    end else if (s[B_PR]) begin
      if (pre[b] == ACTV) sched(b, t, PREC, T_RP, IDLE, 0, IDLE);
      else if (pre[b] != IDLE) ok = 1'b0;
    end else if (s[B_PRA]) begin
      for (int i = 0; i < NB; i++) if (pre[i] != IDLE && pre[i] != ACTV) ok = 1'b0;
      if (ok) for (int i = 0; i < NB; i++) if (pre[i] == ACTV) sched(i, t, PREC, T_RP, IDLE, 0, IDLE);
    end else if (s[B_REF]) begin
      for (int i = 0; i < NB; i++) if (pre[i] != IDLE) ok = 1'b0;
      if (ok) for (int i = 0; i < NB; i++) sched(i, t, REFR, T_RFC, IDLE, 0, IDLE);
    end
    err = !ok;
    if (!ok) exp_eb = b[3:0];
  endtask

  function automatic logic [7:0] one(input int pos);
    return 8'(1 << pos);
  endfunction

  task automatic step(input logic [7:0] s, input int b);
    exp_t e;
    logic err;
    logic [4:0] v;
    @(negedge clk);
    {ACT, RD, RDA, WR, WRA, PR, PRA, REF} = s;
    bg = 2'(b >> 2);
    ba = 2'(b);
    model_edge(s, b, err);
    e.cyc = cyc + 1;
    for (int i = 0; i < NB; i++) begin
      v = view(i, mt);
      e.st[5*i +: 5] = v;
      e.rdy[i]       = (v == IDLE) || (v == ACTV);
    end
    e.err = err;
    e.eb  = exp_eb;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) step(8'h00, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    reset = 1'b1;
    {ACT, RD, RDA, WR, WRA, PR, PRA, REF} = 8'h00;
    #1;
    check("rst_bank_state", 128'(bank_state), 128'(0));
    check("rst_bank_ready", 128'(bank_ready), 128'(16'hFFFF));
    check("rst_cmd_err",    128'(cmd_err),    128'(0));
    check("rst_err_bank",   128'(err_bank),   128'(0));
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!reset) begin
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        if (e.cyc < cyc) check("sb_stale_entry", 128'(e.cyc), 128'(cyc));
        else begin
          check("bank_state", 128'(bank_state), 128'(e.st));
          check("bank_ready", 128'(bank_ready), 128'(e.rdy));
          check("cmd_err",    128'(cmd_err),    128'(e.err));
          check("err_bank",   128'(err_bank),   128'(e.eb));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    do_reset();
    // ACT bank 5, then WR / RD / PR and the auto-precharge variants
    step(one(B_ACT), 5); idle(20);
    step(one(B_WR), 5);  idle(31);
    step(one(B_RD), 5);  idle(22);
    step(one(B_PR), 5);  idle(18);
    step(one(B_ACT), 5); idle(17); step(one(B_WRA), 5); idle(48);
    step(one(B_ACT), 5); idle(17); step(one(B_RDA), 5); idle(39);
    // refresh, and refresh rejected while a bank is activating
    step(one(B_REF), 0); idle(35);
    step(one(B_ACT), 5); step(one(B_REF), 3); idle(17);
    // PRA with banks 2 and 5 open, then back-to-back illegal commands
    step(one(B_ACT), 2); idle(17); step(one(B_PRA), 0); idle(18);
    step(one(B_RD), 0); step(one(B_ACT) | one(B_PR), 9); step(one(B_WR), 0); idle(2);
    step(one(B_PR), 7); idle(1);
    // command on the exit edge is illegal, one edge later it is accepted
    step(one(B_ACT), 5); idle(16); step(one(B_RD), 5); step(one(B_RD), 5); idle(22);
    // reset five clocks into WRITING, then a full tRCD afterwards
    step(one(B_ACT), 2); step(one(B_WR), 5); idle(4);
    do_reset();
    step(one(B_ACT), 5); idle(18);

    for (int i = 0; i < 2500; i++) begin
      int r, b, p, q;
      logic [7:0] s;
      if (i % 500 == 250) begin
        idle(60); step(one(B_PRA), 0); idle(20); step(one(B_REF), 0);
      end
      r = $urandom_range(0, 99);
      b = $urandom_range(0, NB - 1);
      if (r < 40)      s = 8'h00;
      else if (r < 60) s = one(B_ACT);
      else if (r < 68) s = one(B_RD);
      else if (r < 76) s = one(B_WR);
      else if (r < 80) s = one(B_RDA);
      else if (r < 84) s = one(B_WRA);
      else if (r < 92) s = one(B_PR);
      else if (r < 95) s = one(B_PRA);
      else if (r < 97) s = one(B_REF);
      else begin
        p = $urandom_range(0, 7);
        q = (p + 1 + $urandom_range(0, 6)) % 8;
        s = one(p) | one(q);
      end
      step(s, b);
    end

    idle(2);
    repeat (2) @(negedge clk);
    check("sb_drained", 128'(sb.size()), 128'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bank_timing_fsm_array.md
# bank_timing_fsm_array

Parametrised per-bank DRAM timing state machine array for the memory-emulation model. One timing FSM per (bank group, bank) tracks row state and enforces tRCD/tCL/tCWL/tWR/tRP/tRFC with per-bank down-counters. Sits between the command decoder and the bank storage model. Beyond a plain timing tracker, it adds:
- configurable timing parameters;
- all-bank precharge (PRA);
- per-bank ready flags;
- illegal-command detection with error reporting.

## Interface
- BGWIDTH, 2: bank-group address width (0 = no bank groups, DDR3).
- BAWIDTH, 2: bank address width.
- BL, 8: burst length; data occupies BL/2 clocks.
- T_RCD, 17: ACT to RD/WR, clocks.
- T_CL, 17: read latency, clocks.
- T_CWL, 12: write latency, clocks.
- T_WR, 14: write recovery, clocks.
- T_RP, 17: precharge period, clocks.
- T_RFC, 34: refresh period, clocks.
- Derived: NB = 2^(BGWIDTH+BAWIDTH). Bank index b = {bg,ba}.
- Derived: CW = clog2(max(T_CWL+BL/2+T_WR, T_RCD, T_CL+BL/2, T_RP, T_RFC)+1).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- bg  in  max(BGWIDTH,1)  target bank group. Ignored when BGWIDTH=0.
- ba  in  BAWIDTH  target bank.
- ACT, RD, RDA, WR, WRA, PR, PRA, REF  in  1 each  one-hot command strobes, sampled every clock.
- bank_state  out  NB*5  5-bit state per bank; bank b occupies bits [5b+4:5b].
- bank_ready  out  NB  bank b state is IDLE or ACTIVE.
- cmd_err  out  1  one-cycle pulse, registered, the clock after an illegal command.
- err_bank  out  BGWIDTH+BAWIDTH  index addressed by the last illegal command. Held until the next error.

## Operation
State encodings:
- IDLE 5'h00
- ACTIVATING 5'h01
- ACTIVE 5'h03
- READING 5'h04
- WRITING 5'h05
- READ_AP 5'h06
- WRITE_AP 5'h07
- PRECHARGING 5'h08
- REFRESHING 5'h09

Each bank has a CW-bit counter cnt. Timed states count cnt down by 1 per clock. The state exits on the edge where cnt==0.

Legal transitions for the addressed bank (cnt is loaded with duration−1):
- IDLE + ACT → ACTIVATING, duration T_RCD.
- ACTIVATING → ACTIVE on expiry.
- ACTIVE + RD → READING, duration T_CL+BL/2; returns to ACTIVE.
- ACTIVE + WR → WRITING, duration T_CWL+BL/2+T_WR; returns to ACTIVE.
- ACTIVE + RDA → READ_AP, duration T_CL+BL/2; then PRECHARGING.
- ACTIVE + WRA → WRITE_AP, duration T_CWL+BL/2+T_WR; then PRECHARGING.
- ACTIVE + PR → PRECHARGING, duration T_RP; then IDLE.
- IDLE + PR: legal no-op.

All-bank commands:
- PRA: every ACTIVE bank → PRECHARGING (T_RP); IDLE banks unchanged. Legal only if every bank is IDLE or ACTIVE.
- REF: legal only if all banks are IDLE. Every bank → REFRESHING (T_RFC), then IDLE simultaneously.

Illegal commands (no state or counter change anywhere; cmd_err=1 next clock; err_bank←{bg,ba}):
- any command not listed above for the bank's current state;
- more than one strobe high in the same clock.

Non-addressed banks continue counting unaffected by per-bank commands.

## Timing
- Reset asserted (asynchronously):
  - all bank_state = 5'h00;
  - all cnt = 0;
  - bank_ready = all ones;
  - cmd_err = 0;
  - err_bank = 0.
- Reset mid-operation aborts all timed states immediately; no residual count survives.
- Command sampled at edge k: bank_state shows the new state after edge k. A timed state of duration D is visible for exactly D clocks, and the next state appears after edge k+D.
- bank_ready is combinational from registered state, so it is low for the same D clocks.
- A command arriving on the clock the bank returns to ACTIVE/IDLE is judged against the pre-edge state, i.e. it is illegal. The earliest legal command is at edge k+D.
- cmd_err: exactly 1 clock wide. Back-to-back illegal commands give consecutive pulses, with err_bank updated each clock.
- Zero latency in decision; no pipelining of commands to one bank.

## Test plan
- Reset, then ACT bg=1 ba=1 (b=5) at edge 0 → bank_state[29:25]=5'h01 for 17 clocks, 5'h03 from edge 17. bank_ready[5] low for clocks 1–17. Other banks stay 5'h00.
- Bank 5 ACTIVE, WR → 5'h05 for 30 clocks (12+4+14), then 5'h03. Then RD → 5'h04 for 21 clocks, then 5'h03. PR → 5'h08 for 17 clocks, then 5'h00.
- Bank 5 ACTIVE, WRA → 5'h07 for 30 clocks, 5'h08 for 17 clocks, then 5'h00. Repeat with RDA: 5'h06 for 21 clocks, then 5'h08.
- All banks IDLE, REF → all 16 banks 5'h09 for 34 clocks, then 5'h00. REF issued while bank 5 is ACTIVATING → cmd_err pulse, err_bank=5, no state change.
- Banks 2 and 5 ACTIVE, PRA → both 5'h08 for 17 clocks, others stay 5'h00. RD to IDLE bank 0 → cmd_err, err_bank=0. ACT+PR same clock → cmd_err, no change.
- Assert reset 5 clocks into bank 5 WRITING → all states 5'h00 immediately; after deassert, ACT to bank 5 is accepted with full 17-clock tRCD.
